// File: rtl/debug_unit.sv
// Host-side sequencer for the MIPS pipeline: loads instruction memory, gates run/step
// execution and streams PC plus the 32-entry register file back over the byte link.
module debug_unit #(
    parameter int                 NB_ADDR        = 32,
    parameter int                 NB_DATA        = 32,
    parameter int                 NB_REG         = 5,
    parameter int                 NB_BYTE        = 8,
    parameter logic [NB_DATA-1:0] HALT_CODE      = 32'hFFFF_FFFF,
    parameter int                 MAX_RUN_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_mips_enable,
    output logic               o_mips_reset,
    output logic               o_imem_write,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0] o_imem_data,
    output logic [NB_REG-1:0]  o_reg_addr,
    input  logic [NB_DATA-1:0] i_reg_data,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_instruction,
    output logic               o_busy
);

    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_BCNT        = $clog2(BYTES_PER_WORD);
    localparam int ADDR_SHIFT     = $clog2(BYTES_PER_WORD);
    localparam int NB_RUN         = $clog2(MAX_RUN_CYCLES + 1);

    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
    localparam logic [NB_BCNT-1:0] BCNT_ONE  = NB_BCNT'(1);
    localparam logic [NB_RUN-1:0]  RUN_LIMIT = NB_RUN'(MAX_RUN_CYCLES);
    localparam logic [NB_RUN-1:0]  RUN_ONE   = NB_RUN'(1);
    localparam logic [NB_BYTE-1:0] BYTE_ONE  = NB_BYTE'(1);
    localparam logic [NB_REG-1:0]  REG_ONE   = NB_REG'(1);
    localparam logic [NB_REG-1:0]  LAST_REG  = '1;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;
    localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
    localparam logic [NB_BYTE-1:0] CMD_DUMP = 8'h44;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WR,
        ST_LOAD_RST,
        ST_RUN,
        ST_STEP,
        ST_DUMP_PC,
        ST_DUMP_RD,
        ST_DUMP_REG
    } state_t;

    state_t               state_reg,       state_next;
    logic [NB_BYTE-1:0]   word_cnt_reg,    word_cnt_next;
    logic [NB_BYTE-1:0]   word_idx_reg,    word_idx_next;
    logic [NB_BCNT-1:0]   rx_byte_cnt_reg, rx_byte_cnt_next;
    logic [NB_DATA-1:0]   load_word_reg,   load_word_next;
    logic [NB_RUN-1:0]    run_cnt_reg,     run_cnt_next;
    logic [NB_DATA-1:0]   tx_word_reg,     tx_word_next;
    logic [NB_BCNT-1:0]   tx_byte_cnt_reg, tx_byte_cnt_next;
    logic [NB_REG-1:0]    reg_addr_reg,    reg_addr_next;

    logic enter_dump;
    logic run_stop;
    logic tx_fire;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= ST_IDLE;
            word_cnt_reg    <= '0;
            word_idx_reg    <= '0;
            rx_byte_cnt_reg <= '0;
            load_word_reg   <= '0;
            run_cnt_reg     <= '0;
            tx_word_reg     <= '0;
            tx_byte_cnt_reg <= '0;
            reg_addr_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            word_cnt_reg    <= word_cnt_next;
            word_idx_reg    <= word_idx_next;
            rx_byte_cnt_reg <= rx_byte_cnt_next;
            load_word_reg   <= load_word_next;
            run_cnt_reg     <= run_cnt_next;
            tx_word_reg     <= tx_word_next;
            tx_byte_cnt_reg <= tx_byte_cnt_next;
            reg_addr_reg    <= reg_addr_next;
        end
    end

    // The stop condition is combinational so enable drops in the very cycle HALT shows up.
    assign run_stop = (i_instruction == HALT_CODE) || (run_cnt_reg == RUN_LIMIT);
    assign tx_fire  = o_tx_valid && i_tx_ready;

    always_comb begin
        state_next       = state_reg;
        word_cnt_next    = word_cnt_reg;
        word_idx_next    = word_idx_reg;
        rx_byte_cnt_next = rx_byte_cnt_reg;
        load_word_next   = load_word_reg;
        run_cnt_next     = run_cnt_reg;
        tx_word_next     = tx_word_reg;
        tx_byte_cnt_next = tx_byte_cnt_reg;
        reg_addr_next    = reg_addr_reg;
        enter_dump       = 1'b0;
        o_mips_enable    = 1'b0;
        o_mips_reset     = 1'b0;
        o_imem_write     = 1'b0;
        o_tx_valid       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: state_next = ST_LOAD_CNT;
                        CMD_RUN: begin
                            state_next   = ST_RUN;
                            run_cnt_next = '0;
                        end
                        CMD_STEP: state_next = ST_STEP;
                        CMD_DUMP: enter_dump = 1'b1;
                        default:  state_next = ST_IDLE;
                    endcase
                end
            end

            ST_LOAD_CNT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        word_cnt_next    = i_rx_data;
                        word_idx_next    = '0;
                        rx_byte_cnt_next = '0;
                        state_next       = ST_LOAD_BYTE;
                    end
                end
            end

            ST_LOAD_BYTE: begin
                if (i_rx_valid) begin
                    load_word_next   = {load_word_reg[NB_DATA-NB_BYTE-1:0], i_rx_data};
                    rx_byte_cnt_next = rx_byte_cnt_reg + BCNT_ONE;
                    if (rx_byte_cnt_reg == LAST_BYTE) begin
                        state_next = ST_LOAD_WR;
                    end
                end
            end

            ST_LOAD_WR: begin
                o_imem_write = 1'b1;
                if (word_idx_reg == word_cnt_reg - BYTE_ONE) begin
                    state_next = ST_LOAD_RST;
                end else begin
                    word_idx_next = word_idx_reg + BYTE_ONE;
                    state_next    = ST_LOAD_BYTE;
                    // A byte landing here already belongs to the next word.
                    if (i_rx_valid) begin
                        load_word_next   = {load_word_reg[NB_DATA-NB_BYTE-1:0], i_rx_data};
                        rx_byte_cnt_next = rx_byte_cnt_reg + BCNT_ONE;
                    end
                end
            end

            ST_LOAD_RST: begin
                o_mips_reset = 1'b1;
                state_next   = ST_IDLE;
            end

            ST_RUN: begin
                if (run_stop) begin
                    enter_dump = 1'b1;
                end else begin
                    o_mips_enable = 1'b1;
                    run_cnt_next  = run_cnt_reg + RUN_ONE;
                end
            end

            ST_STEP: begin
                o_mips_enable = 1'b1;
                enter_dump    = 1'b1;
            end

            ST_DUMP_PC, ST_DUMP_REG: begin
                o_tx_valid = 1'b1;
                if (tx_fire) begin
                    tx_word_next     = tx_word_reg << NB_BYTE;
                    tx_byte_cnt_next = tx_byte_cnt_reg + BCNT_ONE;
                    if (tx_byte_cnt_reg == LAST_BYTE) begin
                        if (state_reg == ST_DUMP_PC) begin
                            state_next = ST_DUMP_RD;
                        end else if (reg_addr_reg == LAST_REG) begin
                            state_next = ST_IDLE;
                        end else begin
                            reg_addr_next = reg_addr_reg + REG_ONE;
                            state_next    = ST_DUMP_RD;
                        end
                    end
                end
            end

            // One bubble: reg_addr has been stable for a cycle, so read data is valid to latch.
            ST_DUMP_RD: begin
                tx_word_next     = i_reg_data;
                tx_byte_cnt_next = '0;
                state_next       = ST_DUMP_REG;
            end

            default: state_next = ST_IDLE;
        endcase

        if (enter_dump) begin
            state_next       = ST_DUMP_PC;
            tx_word_next     = NB_DATA'(i_pc);
            tx_byte_cnt_next = '0;
            reg_addr_next    = '0;
        end
    end

    assign o_tx_data   = tx_word_reg[NB_DATA-1 -: NB_BYTE];
    assign o_imem_addr = NB_ADDR'(word_idx_reg) << ADDR_SHIFT;
    assign o_imem_data = load_word_reg;
    assign o_reg_addr  = reg_addr_reg;
    assign o_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: a byte-level model of loads, runs and dumps is checked
// against the DUT every cycle, plus literal spot checks on the expected dump stream.
module tb_debug_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_mips_enable;
    logic        o_mips_reset;
    logic        o_imem_write;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_data;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data;
    logic [31:0] i_pc;
    logic [31:0] i_instruction;
    logic        o_busy;

    debug_unit dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_mips_enable (o_mips_enable),
        .o_mips_reset  (o_mips_reset),
        .o_imem_write  (o_imem_write),
        .o_imem_addr   (o_imem_addr),
        .o_imem_data   (o_imem_data),
        .o_reg_addr    (o_reg_addr),
        .i_reg_data    (i_reg_data),
        .i_pc          (i_pc),
        .i_instruction (i_instruction),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Model state: expected streams are appended by the main thread, consumed by the monitor.
    logic [7:0]  exp_tx [0:2047];
    int          exp_tx_n = 0;
    logic [31:0] exp_addr [0:15];
    logic [31:0] exp_data [0:15];
    int          exp_wr_n = 0;

    logic [7:0]  rx_log  [0:2047];
    int          acc_cyc [0:2047];
    int          tx_total = 0;
    int          wr_total = 0;
    int          rst_pulses = 0;
    int          en_edges = 0;
    int          cyc = 0;
    logic        load_phase = 1'b0;

    logic        halt_arm = 1'b0;
    int          halt_after = 0;
    int          en_base = 0;
    logic        rand_mode = 1'b0;
    logic        ready_rand = 1'b1;

    function automatic logic [31:0] reg_val(input logic [4:0] k);
        return 32'(k) * 32'h0101_0101;
    endfunction

    assign i_reg_data    = reg_val(o_reg_addr);
    assign i_tx_ready    = rand_mode ? ready_rand : 1'b1;
    assign i_instruction = (halt_arm && (en_edges - en_base) >= halt_after) ? HALT : 32'h0000_0000;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) begin
            exp_tx[exp_tx_n] = w[b*8 +: 8];
            exp_tx_n++;
        end
    endtask

    task automatic push_dump(input logic [31:0] pc);
        push_word(pc);
        for (int k = 0; k < 32; k++) push_word(reg_val(5'(k)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (o_busy) fail(name);
    endtask

    initial forever begin
        @(posedge i_clk);
        if (o_mips_enable) en_edges++;
    end

    initial forever begin
        @(posedge i_clk); #1;
        ready_rand = 1'($urandom_range(0, 1));
    end

    // Compare process: every negedge, check handshake stability, tx stream and imem writes.
    initial begin
        logic       hold_prev;
        logic [7:0] hold_data;
        hold_prev = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (i_reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("tx_hold_valid", 32'(o_tx_valid), 32'd1);
                    check("tx_hold_data", 32'(o_tx_data), 32'(hold_data));
                end
                if (o_tx_valid && i_tx_ready) begin
                    if (tx_total < exp_tx_n) check($sformatf("tx_byte[%0d]", tx_total), 32'(o_tx_data), 32'(exp_tx[tx_total]));
                    else fail("tx_extra_byte");
                    rx_log[tx_total]  = o_tx_data;
                    acc_cyc[tx_total] = cyc;
                    tx_total++;
                end
                hold_prev = o_tx_valid && !i_tx_ready;
                hold_data = o_tx_data;
                if (o_imem_write) begin
                    if (wr_total < exp_wr_n) begin
                        check("imem_addr", o_imem_addr, exp_addr[wr_total]);
                        check("imem_data", o_imem_data, exp_data[wr_total]);
                    end else begin
                        fail("imem_extra_write");
                    end
                    wr_total++;
                end
                if (o_mips_reset) rst_pulses++;
                if (load_phase) check("enable_in_load", 32'(o_mips_enable), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx_base, wr_base, rst_base, n;
        i_reset    = 1'b1;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_pc       = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_enable", 32'(o_mips_enable), 32'd0);
        check("rst_mips_reset", 32'(o_mips_reset), 32'd0);
        check("rst_imem_write", 32'(o_imem_write), 32'd0);
        check("rst_imem_addr", o_imem_addr, 32'd0);
        check("rst_imem_data", o_imem_data, 32'd0);
        check("rst_reg_addr", 32'(o_reg_addr), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);

        send_byte(8'h58);
        check("unknown_cmd_idle", 32'(o_busy), 32'd0);

        // Two-word load, bytes back to back so word 2 starts during the write cycle.
        wr_base = wr_total; rst_base = rst_pulses; en_base = en_edges;
        exp_addr[exp_wr_n] = 32'h0; exp_data[exp_wr_n] = 32'h0000_0001; exp_wr_n++;
        exp_addr[exp_wr_n] = 32'h4; exp_data[exp_wr_n] = 32'hDEAD_BEEF; exp_wr_n++;
        load_phase = 1'b1;
        send_byte(8'h4C); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_idle("load_timeout", 50);
        load_phase = 1'b0;
        check("load_writes", 32'(wr_total - wr_base), 32'd2);
        check("load_reset_pulses", 32'(rst_pulses - rst_base), 32'd1);
        check("load_enables", 32'(en_edges - en_base), 32'd0);

        // Zero-length load.
        wr_base = wr_total; rst_base = rst_pulses;
        load_phase = 1'b1;
        send_byte(8'h4C); send_byte(8'h00);
        check("load0_idle", 32'(o_busy), 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        load_phase = 1'b0;
        check("load0_writes", 32'(wr_total - wr_base), 32'd0);
        check("load0_reset_pulses", 32'(rst_pulses - rst_base), 32'd0);

        // Single step, ready held high: one enable, 132 bytes, 163 cycles first-to-last.
        i_pc = 32'h10; tx_base = tx_total; en_base = en_edges;
        push_dump(32'h10);
        send_byte(8'h53);
        wait_idle("step_timeout", 400);
        check("step_enables", 32'(en_edges - en_base), 32'd1);
        check("step_bytes", 32'(tx_total - tx_base), 32'd132);
        check("step_pc_lsb", 32'(rx_log[tx_base + 3]), 32'h10);
        check("step_r0_lsb", 32'(rx_log[tx_base + 7]), 32'h00);
        check("step_r1_lsb", 32'(rx_log[tx_base + 11]), 32'h01);
        check("step_r31_lsb", 32'(rx_log[tx_base + 131]), 32'h1F);
        check("step_dump_span", 32'(acc_cyc[tx_base + 131] - acc_cyc[tx_base]), 32'd163);

        // Run halted when HALT appears on the 5th enabled cycle.
        i_pc = 32'h24; tx_base = tx_total; en_base = en_edges;
        halt_after = 4; halt_arm = 1'b1;
        push_dump(32'h24);
        send_byte(8'h52);
        wait_idle("run_halt_timeout", 400);
        halt_arm = 1'b0;
        check("run_halt_enables", 32'(en_edges - en_base), 32'd4);
        check("run_halt_bytes", 32'(tx_total - tx_base), 32'd132);
        check("run_halt_pc_lsb", 32'(rx_log[tx_base + 3]), 32'h24);

        // Run with no HALT: stops at the cycle limit.
        tx_base = tx_total; en_base = en_edges;
        push_dump(32'h24);
        send_byte(8'h52);
        wait_idle("run_limit_timeout", 1500);
        check("run_limit_enables", 32'(en_edges - en_base), 32'd1024);
        check("run_limit_bytes", 32'(tx_total - tx_base), 32'd132);

        // Dump with a randomly stalling host.
        i_pc = 32'h30; tx_base = tx_total; en_base = en_edges;
        push_dump(32'h30);
        rand_mode = 1'b1;
        send_byte(8'h44);
        wait_idle("rand_dump_timeout", 2000);
        rand_mode = 1'b0;
        check("rand_dump_bytes", 32'(tx_total - tx_base), 32'd132);
        check("rand_dump_enables", 32'(en_edges - en_base), 32'd0);

        // Reset in the middle of a dump, then a fresh dump restarts from the PC.
        i_pc = 32'h40; tx_base = tx_total;
        push_dump(32'h40);
        send_byte(8'h44);
        n = 0;
        while ((tx_total - tx_base) < 10 && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        if ((tx_total - tx_base) < 10) fail("mid_dump_wait_timeout");
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check("mid_reset_tx_valid", 32'(o_tx_valid), 32'd0);
        check("mid_reset_busy", 32'(o_busy), 32'd0);
        exp_tx_n = tx_total;
        tx_base = tx_total;
        push_dump(32'h40);
        send_byte(8'h44);
        wait_idle("redump_timeout", 400);
        check("redump_bytes", 32'(tx_total - tx_base), 32'd132);
        check("redump_pc_lsb", 32'(rx_log[tx_base + 3]), 32'h40);

        repeat (2) @(posedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
